// File: rtl/down_count_timer.sv
// Loadable down-counter/timer with an IDLE/RUN/EXPIRED control FSM and one-cycle done pulse.
// Optional build macro DOWN_COUNT_TIMER_AUTO_RELOAD_EN: on expiry in RUN, reload and keep running.
module down_count_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             stop,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             terminal,
  output logic             done,
  output logic             expired
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_EXPIRED = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_r;
  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] reload_r;
  logic             done_r;

  // Control FSM, counter, reload register and done pulse; priority load > stop > start > decrement.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      count_r  <= CNT_ZERO;
      reload_r <= CNT_ZERO;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (load) begin
        count_r  <= load_value;
        reload_r <= load_value;
        if (state_r == ST_EXPIRED) begin
          state_r <= ST_IDLE;
        end else begin
          state_r <= state_r;
        end
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (stop) begin
              state_r <= ST_IDLE;
            end else if (start) begin
              if (count_r != CNT_ZERO) begin
                state_r <= ST_RUN;
              end else begin
                state_r <= ST_EXPIRED;
                done_r  <= 1'b1;
              end
            end else begin
              state_r <= ST_IDLE;
            end
          end
          ST_RUN: begin
            if (stop) begin
              state_r <= ST_IDLE;
            end else if (enable) begin
              if (count_r > CNT_ONE) begin
                count_r <= count_r - CNT_ONE;
              end else if (count_r == CNT_ONE) begin
                done_r <= 1'b1;
`ifdef DOWN_COUNT_TIMER_AUTO_RELOAD_EN
                if (reload_r != CNT_ZERO) begin
                  count_r <= reload_r;
                end else begin
                  count_r <= CNT_ZERO;
                  state_r <= ST_EXPIRED;
                end
`else
                count_r <= CNT_ZERO;
                state_r <= ST_EXPIRED;
`endif
              end else begin
                // A zero loaded while running just parks the counter; it never wraps.
                count_r <= count_r;
              end
            end else begin
              count_r <= count_r;
            end
          end
          ST_EXPIRED: begin
            if (stop) begin
              state_r <= ST_IDLE;
            end else if (start) begin
              count_r <= reload_r;
              if (reload_r != CNT_ZERO) begin
                state_r <= ST_RUN;
              end else begin
                done_r <= 1'b1;
              end
            end else begin
              state_r <= ST_EXPIRED;
            end
          end
          default: begin
            state_r <= ST_IDLE;
            count_r <= CNT_ZERO;
          end
        endcase
      end
    end
  end

  assign count    = count_r;
  assign done     = done_r;
  assign busy     = (state_r == ST_RUN);
  assign expired  = (state_r == ST_EXPIRED);
  assign terminal = (state_r == ST_RUN) & enable & (count_r == CNT_ONE);

endmodule
